// File: rtl/addr_delay_line.sv
// Depth-configurable address/data delay line with run-time tap select, per-stage valids,
// stall, flush and settle indicator. Optional stage parity via `ADDR_DLY_PARITY_EN.
module addr_delay_line #(
  parameter int unsigned DATA_W      = 14,
  parameter int unsigned MAX_DEPTH   = 16,
  parameter int unsigned DEPTH_W     = 5,
  parameter int unsigned DLY_DEFAULT = 9
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               CE,
  input  logic               Flush,
  input  logic               DLY_LOAD,
  input  logic [DEPTH_W-1:0] DLY_SEL,
  input  logic [DATA_W-1:0]  DIN,
  input  logic               DIN_VALID,
  output logic [DATA_W-1:0]  DOUT,
  output logic               DOUT_VALID,
  output logic               BUSY,
  output logic               PERR
);

  localparam int unsigned CNT_W = $clog2(MAX_DEPTH + 2);

  typedef enum logic {RUN, SETTLE} state_e;

  logic [DATA_W-1:0]    s_q [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] v_q;
  logic [DEPTH_W-1:0]   dly_q;
  logic [CNT_W-1:0]     cnt_q;
  state_e               state_q;
  logic [DATA_W-1:0]    dout_q;
  logic                 dout_v_q;

  logic [DATA_W-1:0]    tap_data;
  logic                 tap_valid;
  logic [DEPTH_W-1:0]   sel_clamped;
  logic                 clear;

  assign clear       = Flush | DLY_LOAD;
  assign sel_clamped = (DLY_SEL > DEPTH_W'(MAX_DEPTH)) ? DEPTH_W'(MAX_DEPTH) : DLY_SEL;

`ifdef ADDR_DLY_PARITY_EN
  logic [MAX_DEPTH-1:0] p_q;
  logic                 tap_par;
  logic                 perr_q;
`endif

  // Tap mux: dly_q==0 bypasses the stages; otherwise stage dly_q-1 is selected.
  always_comb begin
    tap_data  = DIN;
    tap_valid = DIN_VALID;
`ifdef ADDR_DLY_PARITY_EN
    tap_par   = ^DIN;
`endif
    for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
      if (dly_q == DEPTH_W'(i + 1)) begin
        tap_data  = s_q[i];
        tap_valid = v_q[i];
`ifdef ADDR_DLY_PARITY_EN
        tap_par   = p_q[i];
`endif
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < MAX_DEPTH; i++) s_q[i] <= '0;
      v_q      <= '0;
      dout_q   <= '0;
      dout_v_q <= 1'b0;
      dly_q    <= DEPTH_W'(DLY_DEFAULT);
      cnt_q    <= '0;
      state_q  <= RUN;
`ifdef ADDR_DLY_PARITY_EN
      p_q      <= '0;
      perr_q   <= 1'b0;
`endif
    end else begin
      if (CE) begin
        s_q[0] <= DIN;
        for (int unsigned i = 1; i < MAX_DEPTH; i++) s_q[i] <= s_q[i-1];
        v_q      <= {v_q[MAX_DEPTH-2:0], DIN_VALID};
        dout_q   <= tap_data;
        dout_v_q <= tap_valid;
`ifdef ADDR_DLY_PARITY_EN
        p_q      <= {p_q[MAX_DEPTH-2:0], ^DIN};
        perr_q   <= tap_valid & ((^tap_data) != tap_par);
`endif
      end
      // Flush/load override the shift so a new-tap output can never pair with stale valids.
      if (clear) begin
        v_q      <= '0;
        dout_v_q <= 1'b0;
`ifdef ADDR_DLY_PARITY_EN
        perr_q   <= 1'b0;
`endif
      end
      if (DLY_LOAD) begin
        dly_q   <= sel_clamped;
        cnt_q   <= CNT_W'(sel_clamped) + CNT_W'(1);
        state_q <= SETTLE;
      end else if (state_q == SETTLE && CE) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_q <= RUN;
      end
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_v_q;
  assign BUSY       = (state_q == SETTLE);
`ifdef ADDR_DLY_PARITY_EN
  assign PERR       = perr_q;
`else
  assign PERR       = 1'b0;
`endif

endmodule

// File: tb/tb_addr_delay_line.sv
// Directed bench for addr_delay_line: queue-based history model checked every cycle,
// plus literal expectations for the key latency/settle/clamp/flush/reset points.
module tb_addr_delay_line;
  localparam int DATA_W    = 14;
  localparam int MAX_DEPTH = 16;
  localparam int DEPTH_W   = 5;

  logic               Clock = 1'b0;
  logic               Reset_n = 1'b0;
  logic               CE = 1'b0;
  logic               Flush = 1'b0;
  logic               DLY_LOAD = 1'b0;
  logic [DEPTH_W-1:0] DLY_SEL = '0;
  logic [DATA_W-1:0]  DIN = '0;
  logic               DIN_VALID = 1'b0;
  logic [DATA_W-1:0]  DOUT;
  logic               DOUT_VALID;
  logic               BUSY;
  logic               PERR;

  always #5 Clock = ~Clock;

  addr_delay_line #(
    .DATA_W(DATA_W), .MAX_DEPTH(MAX_DEPTH), .DEPTH_W(DEPTH_W), .DLY_DEFAULT(9)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .CE(CE), .Flush(Flush), .DLY_LOAD(DLY_LOAD),
    .DLY_SEL(DLY_SEL), .DIN(DIN), .DIN_VALID(DIN_VALID), .DOUT(DOUT),
    .DOUT_VALID(DOUT_VALID), .BUSY(BUSY), .PERR(PERR)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [DATA_W-1:0] d; logic v; } ent_t;
  ent_t        hist[$];
  int          mdly;
  int          busy_left;
  logic [DATA_W-1:0] exp_dout;
  logic        exp_dv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ent_t z;
    z.d = '0;
    z.v = 1'b0;
    hist.delete();
    for (int i = 0; i < MAX_DEPTH; i++) hist.push_back(z);
    mdly      = 9;
    busy_left = 0;
    exp_dout  = '0;
    exp_dv    = 1'b0;
  endtask

  // hist holds what entered the line on the last MAX_DEPTH CE edges, newest at the back.
  task automatic model_edge();
    ent_t e;
    int   sel;
    if (CE) begin
      if (mdly == 0) begin
        exp_dout = DIN;
        exp_dv   = DIN_VALID;
      end else begin
        e = hist[hist.size() - mdly];
        exp_dout = e.d;
        exp_dv   = e.v;
      end
      e.d = DIN;
      e.v = DIN_VALID;
      hist.push_back(e);
      void'(hist.pop_front());
    end
    if (Flush || DLY_LOAD) begin
      foreach (hist[i]) hist[i].v = 1'b0;
      exp_dv = 1'b0;
    end
    if (DLY_LOAD) begin
      sel       = int'(DLY_SEL);
      mdly      = (sel > MAX_DEPTH) ? MAX_DEPTH : sel;
      busy_left = mdly + 1;
    end else if (CE && busy_left > 0) begin
      busy_left--;
    end
  endtask

  task automatic compare();
    chk("dout",       32'(DOUT),       32'(exp_dout));
    chk("dout_valid", 32'(DOUT_VALID), 32'(exp_dv));
    chk("busy",       32'(BUSY),       32'(busy_left != 0));
    chk("perr",       32'(PERR),       32'(0));
  endtask

  task automatic step(input logic ce, input logic fl, input logic ld, input int sel,
                      input int din, input logic dv);
    CE        = ce;
    Flush     = fl;
    DLY_LOAD  = ld;
    DLY_SEL   = DEPTH_W'(sel);
    DIN       = DATA_W'(din);
    DIN_VALID = dv;
    @(posedge Clock);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    model_reset();
    Reset_n = 1'b0;
    #12;
    chk("rst_dout",  32'(DOUT),       32'h0);
    chk("rst_dv",    32'(DOUT_VALID), 32'h0);
    chk("rst_busy",  32'(BUSY),       32'h0);
    chk("rst_perr",  32'(PERR),       32'h0);
    Reset_n = 1'b1;

    // Default tap 9: first sample emerges on the 10th edge.
    for (int i = 1; i <= 32; i++) begin
      step(1, 0, 0, 0, i, 1);
      if (i == 9)  chk("t1_not_yet", 32'(DOUT_VALID), 32'h0);
      if (i == 10) begin
        chk("t1_first_dout", 32'(DOUT), 32'h1);
        chk("t1_first_dv",   32'(DOUT_VALID), 32'h1);
      end
      if (i == 11) chk("t1_second_dout", 32'(DOUT), 32'h2);
    end

    // Load tap 3 mid-stream.
    step(1, 0, 1, 3, 'h100, 1);
    chk("t2_busy_load", 32'(BUSY), 32'h1);
    for (int j = 1; j <= 8; j++) begin
      step(1, 0, 0, 0, 'h100 + j, 1);
      if (j == 3) begin
        chk("t2_busy_j3", 32'(BUSY), 32'h1);
        chk("t2_dv_j3",   32'(DOUT_VALID), 32'h0);
      end
      if (j == 4) begin
        chk("t2_busy_j4", 32'(BUSY), 32'h0);
        chk("t2_dout_j4", 32'(DOUT), 32'h101);
        chk("t2_dv_j4",   32'(DOUT_VALID), 32'h1);
      end
    end

    // Tap 0 bypass, then out-of-range select clamps to MAX_DEPTH.
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 'h2ABC, 1);
    chk("t3_bypass_dout", 32'(DOUT), 32'h2ABC);
    chk("t3_bypass_dv",   32'(DOUT_VALID), 32'h1);
    step(1, 0, 1, 31, 0, 0);
    step(1, 0, 0, 0, 'h1555, 1);
    for (int j = 2; j <= 18; j++) begin
      step(1, 0, 0, 0, j, 0);
      if (j == 16) chk("t3_clamp_early", 32'(DOUT_VALID), 32'h0);
      if (j == 17) begin
        chk("t3_clamp_dout", 32'(DOUT), 32'h1555);
        chk("t3_clamp_dv",   32'(DOUT_VALID), 32'h1);
      end
    end

    // Stall for 5 cycles mid-stream at tap 9.
    step(1, 0, 1, 9, 0, 0);
    for (int j = 1; j <= 12; j++) step(1, 0, 0, 0, 'h200 + j, 1);
    for (int j = 0; j < 5; j++) step(0, 0, 0, 0, 'h3FFF, 1);
    for (int r = 1; r <= 12; r++) begin
      step(1, 0, 0, 0, 'h20C + r, 1);
      if (r == 1) chk("t4_resume1", 32'(DOUT), 32'h204);
      if (r == 2) chk("t4_resume2", 32'(DOUT), 32'h205);
    end

    // Flush mid-stream, then a stream with holes.
    step(1, 1, 0, 0, 'h300, 1);
    chk("t5_flush_dv", 32'(DOUT_VALID), 32'h0);
    for (int j = 1; j <= 14; j++) begin
      step(1, 0, 0, 0, 'h300 + j, (j % 3) != 0);
      if (j == 9)  chk("t5_dv_j9",   32'(DOUT_VALID), 32'h0);
      if (j == 10) begin
        chk("t5_dout_j10", 32'(DOUT), 32'h301);
        chk("t5_dv_j10",   32'(DOUT_VALID), 32'h1);
      end
      if (j == 12) chk("t5_hole_j12", 32'(DOUT_VALID), 32'h0);
    end
    step(0, 1, 0, 0, 'h3AA, 1);
    for (int j = 0; j < 4; j++) step(1, 0, 0, 0, 'h3B0 + j, 1);
    step(1, 1, 1, 2, 'h3C0, 1);
    for (int j = 0; j < 6; j++) step(1, 0, 0, 0, 'h3D0 + j, 1);

    // Async reset between edges while settling.
    step(1, 0, 1, 5, 'h400, 1);
    step(1, 0, 0, 0, 'h401, 1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("t6_rst_dout", 32'(DOUT),       32'h0);
    chk("t6_rst_dv",   32'(DOUT_VALID), 32'h0);
    chk("t6_rst_busy", 32'(BUSY),       32'h0);
    model_reset();
    #3;
    Reset_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step(1, 0, 0, 0, 'h500 + j, 1);
      if (j == 10) chk("t6_default_tap", 32'(DOUT), 32'h501);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
